// File: rtl/router_pkg.sv
// Shared router types and constants used by the synthetic traffic generator.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package router_pkg;

    localparam int FLIT_SIZE       = 32;
    localparam int MAX_PKT_LEN_DEF = 8;

    // Flit type lives in the two top bits of every flit.
    localparam int FLIT_TYPE_W = 2;

    // Head flit layout, low to high: dest, src, length; scaled by DEST_W at use.
    localparam int HEAD_DEST_SLOT = 0;
    localparam int HEAD_SRC_SLOT  = 1;
    localparam int HEAD_LEN_SLOT  = 2;

    // Body/tail flits carry a 16-bit sequence number in the low payload bits.
    localparam int BODY_SEQ_W = 16;

    typedef enum logic [1:0] {
        BODY     = 2'b00,
        TAIL     = 2'b01,
        HEAD     = 2'b10,
        HEADTAIL = 2'b11
    } flit_type_t;

    typedef enum logic [1:0] {
        TG_FIXED   = 2'd0,
        TG_UNIFORM = 2'd1,
        TG_BITCOMP = 2'd2
    } tg_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GAP,
        ST_SEND,
        ST_DONE
    } tg_state_t;

    // 16-bit Fibonacci LFSR step, polynomial x^16 + x^14 + x^13 + x^11 + 1.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
    endfunction

endpackage

// File: rtl/tg_lfsr16.sv
// Destination LFSR for the traffic generator; ports: clk, reset, i_advance, o_value.
// Latency: o_value updates on the edge where i_advance is sampled high.
// Backpressure: none; holds its value while i_advance is low.
module tg_lfsr16
    import router_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_advance,
    output logic [15:0] o_value
);

    always_ff @(posedge clk) begin
        if (reset) begin
            o_value <= SEED;
        end else if (i_advance) begin
            o_value <= lfsr_step(o_value);
        end
    end

endmodule

// File: rtl/traffic_gen_param.sv
// Synthetic NoC traffic generator: head/body/tail packets, selectable dest pattern, gap, budget, counters.
// Latency: head valid one cycle after i_start is sampled high; back-to-back heads with zero gap.
// Backpressure: o_valid/o_flit held stable while i_ready is low; counters advance only on handshakes.
module traffic_gen_param
    import router_pkg::*;
#(
    parameter int          FLIT_W      = FLIT_SIZE,
    parameter int          NUM_NODES   = 16,
    parameter int          SRC_ID      = 0,
    parameter int          MAX_PKT_LEN = MAX_PKT_LEN_DEF,
    parameter int          GAP_W       = 8,
    parameter int          CNT_W       = 16,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1,
    localparam int         DEST_W      = $clog2(NUM_NODES),
    localparam int         LEN_W       = $clog2(MAX_PKT_LEN + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_start,
    input  logic [1:0]        i_mode,
    input  logic [DEST_W-1:0] i_fixed_dest,
    input  logic [LEN_W-1:0]  i_pkt_len,
    input  logic [GAP_W-1:0]  i_gap,
    input  logic [CNT_W-1:0]  i_num_pkts,
    output logic [FLIT_W-1:0] o_flit,
    output logic              o_valid,
    input  logic              i_ready,
    output logic              o_busy,
    output logic              o_done,
    output logic [CNT_W-1:0]  o_pkt_count,
    output logic [CNT_W-1:0]  o_flit_count
);

    localparam logic [DEST_W-1:0] SRC   = DEST_W'(SRC_ID);
    localparam int                PKT_W = FLIT_W - FLIT_TYPE_W - BODY_SEQ_W;

    tg_state_t         state;
    logic [1:0]        cfg_mode;
    logic [DEST_W-1:0] cfg_fixed;
    logic [LEN_W-1:0]  cfg_len;
    logic [GAP_W-1:0]  cfg_gap;
    logic [CNT_W-1:0]  cfg_budget;
    logic [LEN_W-1:0]  idx;
    logic [GAP_W-1:0]  gap_cnt;
    logic [CNT_W-1:0]  run_cnt;
    logic [15:0]       lfsr_val;
    logic [LEN_W-1:0]  eff_len;
    logic              lfsr_adv;
    logic [DEST_W-1:0] head_rnd;
    logic              is_tail;
    logic              budget_hit;

    function automatic logic [DEST_W-1:0] pick_dest(input logic [1:0]        mode,
                                                    input logic [DEST_W-1:0] fixed,
                                                    input logic [DEST_W-1:0] rnd);
        logic [DEST_W-1:0] d;
        case (mode)
            TG_UNIFORM: d = (rnd == SRC) ? rnd + DEST_W'(1) : rnd;  // wraps mod NUM_NODES
            TG_BITCOMP: d = ~SRC;
            default:    d = fixed;
        endcase
        return d;
    endfunction

    function automatic logic [FLIT_W-1:0] head_flit(input logic [DEST_W-1:0] dest,
                                                    input logic [LEN_W-1:0]  len);
        logic [FLIT_W-1:0] f;
        f = '0;
        f[FLIT_W-1 -: FLIT_TYPE_W]         = (len == LEN_W'(1)) ? HEADTAIL : HEAD;
        f[HEAD_DEST_SLOT*DEST_W +: DEST_W] = dest;
        f[HEAD_SRC_SLOT*DEST_W +: DEST_W]  = SRC;
        f[HEAD_LEN_SLOT*DEST_W +: LEN_W]   = len;
        return f;
    endfunction

    function automatic logic [FLIT_W-1:0] body_flit(input logic             last,
                                                    input logic [CNT_W-1:0] seq,
                                                    input logic [CNT_W-1:0] pkt);
        logic [FLIT_W-1:0] f;
        f = '0;
        f[FLIT_W-1 -: FLIT_TYPE_W]        = last ? TAIL : BODY;
        f[BODY_SEQ_W-1:0]                 = BODY_SEQ_W'(seq);
        f[BODY_SEQ_W +: PKT_W]            = PKT_W'(pkt);
        return f;
    endfunction

    always_comb begin
        eff_len = i_pkt_len;
        if (i_pkt_len == '0) begin
            eff_len = LEN_W'(1);
        end else if (i_pkt_len > LEN_W'(MAX_PKT_LEN)) begin
            eff_len = LEN_W'(MAX_PKT_LEN);
        end
    end

    assign lfsr_adv   = (state == ST_SEND) && i_ready && (idx == '0);
    assign is_tail    = (idx == cfg_len - LEN_W'(1));
    assign budget_hit = (cfg_budget != '0) && (run_cnt + CNT_W'(1) == cfg_budget);
    // A single-flit packet advances the LFSR on the same edge that builds the
    // next head, so the next head must see the post-advance value.
    assign head_rnd   = DEST_W'(lfsr_adv ? lfsr_step(lfsr_val) : lfsr_val);

    tg_lfsr16 #(
        .SEED(LFSR_SEED)
    ) u_lfsr (
        .clk      (clk),
        .reset    (reset),
        .i_advance(lfsr_adv),
        .o_value  (lfsr_val)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            o_flit       <= '0;
            o_valid      <= 1'b0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_pkt_count  <= '0;
            o_flit_count <= '0;
            cfg_mode     <= 2'd0;
            cfg_fixed    <= '0;
            cfg_len      <= LEN_W'(1);
            cfg_gap      <= '0;
            cfg_budget   <= '0;
            idx          <= '0;
            gap_cnt      <= '0;
            run_cnt      <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        cfg_mode   <= i_mode;
                        cfg_fixed  <= i_fixed_dest;
                        cfg_len    <= eff_len;
                        cfg_gap    <= i_gap;
                        cfg_budget <= i_num_pkts;
                        run_cnt    <= '0;
                        idx        <= '0;
                        o_flit     <= head_flit(pick_dest(i_mode, i_fixed_dest, head_rnd), eff_len);
                        o_valid    <= 1'b1;
                        o_busy     <= 1'b1;
                        state      <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (i_ready) begin
                        o_flit_count <= o_flit_count + CNT_W'(1);
                        if (is_tail) begin
                            o_pkt_count <= o_pkt_count + CNT_W'(1);
                            run_cnt     <= run_cnt + CNT_W'(1);
                            idx         <= '0;
                            if (budget_hit) begin
                                o_valid <= 1'b0;
                                o_busy  <= 1'b0;
                                o_done  <= 1'b1;
                                state   <= ST_DONE;
                            end else if (!i_start) begin
                                o_valid <= 1'b0;
                                o_busy  <= 1'b0;
                                state   <= ST_IDLE;
                            end else if (cfg_gap != '0) begin
                                o_valid <= 1'b0;
                                o_busy  <= 1'b0;
                                gap_cnt <= cfg_gap;
                                state   <= ST_GAP;
                            end else begin
                                o_flit <= head_flit(pick_dest(cfg_mode, cfg_fixed, head_rnd), cfg_len);
                            end
                        end else begin
                            idx    <= idx + LEN_W'(1);
                            // Sequence number is the flit count after this handshake.
                            o_flit <= body_flit(idx + LEN_W'(1) == cfg_len - LEN_W'(1),
                                                o_flit_count + CNT_W'(1), o_pkt_count);
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_W'(1)) begin
                        o_flit  <= head_flit(pick_dest(cfg_mode, cfg_fixed, head_rnd), cfg_len);
                        o_valid <= 1'b1;
                        o_busy  <= 1'b1;
                        state   <= ST_SEND;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
                ST_DONE: begin
                    if (!i_start) begin
                        o_done <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_traffic_gen_param.sv
// Self-checking bench for traffic_gen_param with a packet-level reference model.
// Latency: checks 1-cycle start latency, back-to-back heads and exact gap length.
// Backpressure: random and long i_ready stalls, checking flit stability.
module tb_traffic_gen_param;

    localparam int SRC = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_start;
    logic [1:0]  i_mode;
    logic [3:0]  i_fixed_dest;
    logic [3:0]  i_pkt_len;
    logic [7:0]  i_gap;
    logic [15:0] i_num_pkts;
    logic [31:0] o_flit;
    logic        o_valid;
    logic        i_ready;
    logic        o_busy;
    logic        o_done;
    logic [15:0] o_pkt_count;
    logic [15:0] o_flit_count;

    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] m_lfsr;
    int          m_flits;
    int          m_pkts;

    traffic_gen_param #(
        .FLIT_W(32), .NUM_NODES(16), .SRC_ID(SRC), .MAX_PKT_LEN(8),
        .GAP_W(8), .CNT_W(16), .LFSR_SEED(16'hACE1)
    ) dut (
        .clk(clk), .reset(reset), .i_start(i_start), .i_mode(i_mode),
        .i_fixed_dest(i_fixed_dest), .i_pkt_len(i_pkt_len), .i_gap(i_gap),
        .i_num_pkts(i_num_pkts), .o_flit(o_flit), .o_valid(o_valid),
        .i_ready(i_ready), .o_busy(o_busy), .o_done(o_done),
        .o_pkt_count(o_pkt_count), .o_flit_count(o_flit_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] exp_head(input int dest, input int len);
        logic [31:0] r;
        r = (len == 1) ? 32'hC000_0000 : 32'h8000_0000;
        return r | (32'(len) << 8) | (32'(SRC) << 4) | 32'(dest);
    endfunction

    function automatic logic [31:0] exp_body(input bit last, input int seq, input int pkt);
        logic [31:0] r;
        r = last ? 32'h4000_0000 : 32'h0;
        return r | ((32'(pkt) & 32'h3FFF) << 16) | (32'(seq) & 32'hFFFF);
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        logic fb;
        fb = v[0] ^ v[2] ^ v[3] ^ v[5];
        return {fb, v[15:1]};
    endfunction

    function automatic int model_dest(input int mode, input int fixed);
        int d;
        if (mode == 1) begin
            d = int'(m_lfsr) % 16;
            if (d == SRC) d = (d + 1) % 16;
        end else if (mode == 2) begin
            d = (~SRC) & 15;
        end else begin
            d = fixed;
        end
        return d;
    endfunction

    task automatic model_reset();
        m_lfsr  = 16'hACE1;
        m_flits = 0;
        m_pkts  = 0;
    endtask

    // Expected flit at position idx of a len-flit packet; also accounts for its acceptance.
    task automatic model_flit(input int mode, input int fixed, input int len, input int idx,
                              output logic [31:0] e);
        if (idx == 0) begin
            e      = exp_head(model_dest(mode, fixed), len);
            m_lfsr = lfsr_next(m_lfsr);
        end else begin
            e = exp_body(idx == len - 1, m_flits, m_pkts);
        end
        m_flits = (m_flits + 1) % 65536;
        if (idx == len - 1) m_pkts = (m_pkts + 1) % 65536;
    endtask

    // Waits (bounded) for a handshake; returns the accepted flit at the next negedge.
    task automatic collect_flit(input int limit, input bit rnd_ready, input bit drop_start,
                                output logic [31:0] f, output int waited, output bit ok);
        ok = 1'b0; waited = 0; f = '0;
        for (int k = 0; k < limit; k++) begin
            if (rnd_ready) i_ready = ($urandom_range(0, 3) != 0);
            if (o_valid && i_ready) begin
                f  = o_flit;
                ok = 1'b1;
                break;
            end
            waited++;
            @(negedge clk);
        end
        if (ok) begin
            if (drop_start) i_start = 1'b0;
            @(negedge clk);
            i_ready = 1'b1;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1; i_start = 1'b0; i_ready = 1'b1; i_mode = 2'd0;
        i_fixed_dest = '0; i_pkt_len = 4'd1; i_gap = '0; i_num_pkts = '0;
        repeat (3) @(negedge clk);
        n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", o_valid); end
        n_vec++; if (o_flit !== 32'h0) begin n_err++; $display("FAIL reset_flit: got %h want 0", o_flit); end
        n_vec++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", o_busy); end
        n_vec++; if (o_done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", o_done); end
        n_vec++; if (o_pkt_count !== 16'd0) begin n_err++; $display("FAIL reset_pkts: got %0d want 0", o_pkt_count); end
        n_vec++; if (o_flit_count !== 16'd0) begin n_err++; $display("FAIL reset_flits: got %0d want 0", o_flit_count); end
        reset = 1'b0;
        model_reset();
        @(negedge clk);
    endtask

    task automatic test_fixed_budget();
        logic [31:0] f, e; int w; bit ok;
        i_mode = 2'd0; i_fixed_dest = 4'd5; i_pkt_len = 4'd3; i_gap = 8'd0; i_num_pkts = 16'd2;
        i_start = 1'b1;
        for (int k = 0; k < 6; k++) begin
            collect_flit(20, 1'b0, 1'b0, f, w, ok);
            n_vec++; if (!ok) begin n_err++; $display("FAIL fixed_timeout: flit %0d never valid", k); return; end
            model_flit(0, 5, 3, k % 3, e);
            n_vec++; if (f !== e) begin n_err++; $display("FAIL fixed_flit%0d: got %h want %h", k, f, e); end
            if (k == 0) begin
                n_vec++; if (w != 1) begin n_err++; $display("FAIL start_latency: got %0d idle want 1", w); end
            end
            if (k == 3) begin
                n_vec++; if (w != 0) begin n_err++; $display("FAIL back_to_back: got %0d idle want 0", w); end
            end
        end
        n_vec++; if (o_done !== 1'b1) begin n_err++; $display("FAIL fixed_done: got %b want 1", o_done); end
        n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL fixed_done_valid: got %b want 0", o_valid); end
        n_vec++; if (o_pkt_count !== 16'(m_pkts)) begin n_err++; $display("FAIL fixed_pkts: got %0d want %0d", o_pkt_count, m_pkts); end
        n_vec++; if (o_flit_count !== 16'(m_flits)) begin n_err++; $display("FAIL fixed_flits: got %0d want %0d", o_flit_count, m_flits); end
        i_start = 1'b0;
        @(negedge clk);
        n_vec++; if (o_done !== 1'b0) begin n_err++; $display("FAIL done_release: got %b want 0", o_done); end
    endtask

    task automatic test_bitcomp_gap();
        logic [31:0] f, e; int w; bit ok;
        i_mode = 2'd2; i_fixed_dest = 4'($urandom_range(0, 15)); i_pkt_len = 4'd1;
        i_gap = 8'd4; i_num_pkts = 16'd0; i_start = 1'b1;
        for (int k = 0; k < 5; k++) begin
            collect_flit(20, 1'b0, k == 4, f, w, ok);
            n_vec++; if (!ok) begin n_err++; $display("FAIL bitcomp_timeout: flit %0d", k); return; end
            model_flit(2, 0, 1, 0, e);
            n_vec++; if (f !== e) begin n_err++; $display("FAIL bitcomp_flit%0d: got %h want %h", k, f, e); end
            n_vec++; if (w != ((k == 0) ? 1 : 4)) begin n_err++; $display("FAIL gap_len%0d: got %0d idle want %0d", k, w, (k == 0) ? 1 : 4); end
        end
        for (int c = 0; c < 6; c++) begin
            n_vec++; if (o_valid !== 1'b0 || o_busy !== 1'b0) begin n_err++; $display("FAIL bitcomp_idle%0d: valid %b busy %b want 0 0", c, o_valid, o_busy); end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] f, e, held; logic [15:0] cnt; int w; bit ok; int dest;
        dest = $urandom_range(0, 15);
        i_mode = 2'd0; i_fixed_dest = 4'(dest); i_pkt_len = 4'd6; i_gap = 8'd0; i_num_pkts = 16'd1;
        i_start = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (k == 2) begin
                i_ready = 1'b0; held = o_flit; cnt = o_flit_count;
                for (int c = 0; c < 7; c++) begin
                    @(negedge clk);
                    n_vec++; if (o_valid !== 1'b1 || o_flit !== held || o_flit_count !== cnt) begin
                        n_err++; $display("FAIL stall%0d: valid %b flit %h cnt %0d want 1 %h %0d", c, o_valid, o_flit, o_flit_count, held, cnt);
                    end
                end
                i_ready = 1'b1;
            end
            collect_flit(20, 1'b0, 1'b0, f, w, ok);
            n_vec++; if (!ok) begin n_err++; $display("FAIL bp_timeout: flit %0d", k); return; end
            model_flit(0, dest, 6, k, e);
            n_vec++; if (f !== e) begin n_err++; $display("FAIL bp_flit%0d: got %h want %h", k, f, e); end
        end
        n_vec++; if (o_done !== 1'b1) begin n_err++; $display("FAIL bp_done: got %b want 1", o_done); end
        i_start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_start_drop();
        logic [31:0] f, e; int w; bit ok; int dest;
        dest = $urandom_range(0, 15);
        i_mode = 2'd0; i_fixed_dest = 4'(dest); i_pkt_len = 4'd4; i_gap = 8'd0; i_num_pkts = 16'd0;
        i_start = 1'b1;
        for (int k = 0; k < 4; k++) begin
            collect_flit(20, 1'b0, k == 0, f, w, ok);
            n_vec++; if (!ok) begin n_err++; $display("FAIL drop_timeout: flit %0d", k); return; end
            model_flit(0, dest, 4, k, e);
            n_vec++; if (f !== e) begin n_err++; $display("FAIL drop_flit%0d: got %h want %h", k, f, e); end
        end
        for (int c = 0; c < 5; c++) begin
            n_vec++; if (o_valid !== 1'b0 || o_busy !== 1'b0) begin n_err++; $display("FAIL drop_idle%0d: valid %b busy %b want 0 0", c, o_valid, o_busy); end
            @(negedge clk);
        end
        n_vec++; if (o_pkt_count !== 16'(m_pkts)) begin n_err++; $display("FAIL drop_pkts: got %0d want %0d", o_pkt_count, m_pkts); end
    endtask

    task automatic test_length_clamp();
        logic [31:0] f, e; int w; bit ok; int dest;
        int req [2] = '{0, 15};
        int eff [2] = '{1, 8};
        for (int r = 0; r < 2; r++) begin
            dest = $urandom_range(0, 15);
            i_mode = 2'd0; i_fixed_dest = 4'(dest); i_pkt_len = 4'(req[r]); i_gap = 8'd1; i_num_pkts = 16'd1;
            i_start = 1'b1;
            for (int k = 0; k < eff[r]; k++) begin
                collect_flit(20, 1'b0, 1'b0, f, w, ok);
                n_vec++; if (!ok) begin n_err++; $display("FAIL len_timeout: len %0d flit %0d", req[r], k); return; end
                model_flit(0, dest, eff[r], k, e);
                n_vec++; if (f !== e) begin n_err++; $display("FAIL len%0d_flit%0d: got %h want %h", req[r], k, f, e); end
            end
            n_vec++; if (o_done !== 1'b1) begin n_err++; $display("FAIL len%0d_done: got %b want 1", req[r], o_done); end
            i_start = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_uniform();
        logic [31:0] f, e; int w; bit ok; int len;
        len = $urandom_range(1, 8);
        i_mode = 2'd1; i_fixed_dest = 4'd3; i_pkt_len = 4'(len); i_gap = 8'($urandom_range(0, 2));
        i_num_pkts = 16'd32; i_start = 1'b1;
        for (int p = 0; p < 32; p++) begin
            for (int k = 0; k < len; k++) begin
                collect_flit(60, 1'b1, 1'b0, f, w, ok);
                n_vec++; if (!ok) begin n_err++; $display("FAIL uni_timeout: pkt %0d flit %0d", p, k); return; end
                model_flit(1, 0, len, k, e);
                n_vec++; if (f !== e) begin n_err++; $display("FAIL uni_p%0d_f%0d: got %h want %h", p, k, f, e); end
                if (k == 0) begin
                    n_vec++; if (f[3:0] == 4'(SRC)) begin n_err++; $display("FAIL uni_self_dest%0d: got %0d must differ from %0d", p, f[3:0], SRC); end
                end
            end
        end
        n_vec++; if (o_done !== 1'b1) begin n_err++; $display("FAIL uni_done: got %b want 1", o_done); end
        n_vec++; if (o_pkt_count !== 16'(m_pkts)) begin n_err++; $display("FAIL uni_pkts: got %0d want %0d", o_pkt_count, m_pkts); end
        n_vec++; if (o_flit_count !== 16'(m_flits)) begin n_err++; $display("FAIL uni_flits: got %0d want %0d", o_flit_count, m_flits); end
        i_start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [31:0] f, e; int w; bit ok; int seed_dest;
        i_mode = 2'd1; i_pkt_len = 4'd5; i_gap = 8'd0; i_num_pkts = 16'd0; i_start = 1'b1;
        for (int k = 0; k < 2; k++) begin
            collect_flit(20, 1'b0, 1'b0, f, w, ok);
            n_vec++; if (!ok) begin n_err++; $display("FAIL rmid_timeout: flit %0d", k); return; end
            model_flit(1, 0, 5, k, e);
            n_vec++; if (f !== e) begin n_err++; $display("FAIL rmid_flit%0d: got %h want %h", k, f, e); end
        end
        reset = 1'b1; i_start = 1'b0;
        @(negedge clk);
        n_vec++; if (o_valid !== 1'b0 || o_busy !== 1'b0) begin n_err++; $display("FAIL rmid_valid: valid %b busy %b want 0 0", o_valid, o_busy); end
        n_vec++; if (o_pkt_count !== 16'd0 || o_flit_count !== 16'd0) begin n_err++; $display("FAIL rmid_counts: got %0d %0d want 0 0", o_pkt_count, o_flit_count); end
        reset = 1'b0;
        model_reset();
        seed_dest = int'(16'hACE1) % 16;
        if (seed_dest == SRC) seed_dest = (seed_dest + 1) % 16;
        i_pkt_len = 4'd2; i_num_pkts = 16'd1; i_start = 1'b1;
        for (int k = 0; k < 2; k++) begin
            collect_flit(20, 1'b0, 1'b0, f, w, ok);
            n_vec++; if (!ok) begin n_err++; $display("FAIL restart_timeout: flit %0d", k); return; end
            model_flit(1, 0, 2, k, e);
            n_vec++; if (f !== e) begin n_err++; $display("FAIL restart_flit%0d: got %h want %h", k, f, e); end
            if (k == 0) begin
                n_vec++; if (int'(f[3:0]) != seed_dest) begin n_err++; $display("FAIL restart_dest: got %0d want %0d", f[3:0], seed_dest); end
            end
        end
        n_vec++; if (o_done !== 1'b1) begin n_err++; $display("FAIL restart_done: got %b want 1", o_done); end
        i_start = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_fixed_budget();
        test_bitcomp_gap();
        test_backpressure();
        test_start_drop();
        test_length_clamp();
        test_uniform();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/traffic_gen_param.md
Name: traffic_gen_param

Overview:
- Parametrised synthetic traffic generator for NoC router bring-up and characterisation. It is the next generation of the single-mode generator.
- Emits multi-flit packets (head/body/tail) on a valid/ready local-port interface toward a router injection port.
- Supports selectable destination patterns, programmable packet length, inter-packet gap and packet budget.
- Exposes packet/flit counters for throughput checks.

Parameters:
- FLIT_W, FLIT_SIZE (router_pkg), flit width in bits; minimum 24.
- NUM_NODES, 16, number of network nodes; power of two.
- SRC_ID, 0, this generator's node id, 0..NUM_NODES-1.
- MAX_PKT_LEN, 8, maximum flits per packet, including head.
- GAP_W, 8, width of the inter-packet gap field.
- CNT_W, 16, width of the packet budget and status counters.
- LFSR_SEED, 16'hACE1, reset seed of the destination LFSR; must be non-zero.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- i_start  in  1  level: run while high.
- i_mode  in  2  0=fixed, 1=uniform random, 2=bit-complement, 3=reserved (behaves as fixed).
- i_fixed_dest  in  DEST_W  destination used in mode 0.
- i_pkt_len  in  LEN_W  flits per packet.
- i_gap  in  GAP_W  idle cycles between packets.
- i_num_pkts  in  CNT_W  packet budget; 0 = unlimited.
- o_flit  out  FLIT_W  flit data.
- o_valid  out  1  flit valid.
- i_ready  in  1  downstream accepts the flit.
- o_busy  out  1  a packet is in progress.
- o_done  out  1  budget exhausted; level signal.
- o_pkt_count  out  CNT_W  completed packets (tail handshakes).
- o_flit_count  out  CNT_W  accepted flits.

Behaviour:
- Widths: DEST_W=$clog2(NUM_NODES); LEN_W=$clog2(MAX_PKT_LEN+1).
- Flit format: [FLIT_W-1:FLIT_W-2] type: HEAD=2'b10, BODY=2'b00, TAIL=2'b01, HEADTAIL=2'b11.
- Head flit payload: dest at [DEST_W-1:0]; src at [2*DEST_W-1:DEST_W]; length at the next LEN_W bits; remaining bits 0.
- Body/tail flit payload: 16-bit flit sequence number (o_flit_count at generation, zero-extended or truncated); the remaining upper payload bits hold the packet index.
- Reset: FSM in IDLE; o_valid=0, o_flit=0, o_busy=0, o_done=0; both counters 0; LFSR=LFSR_SEED.
- FSM states are IDLE, GAP, SEND, DONE.
- IDLE: stays while i_start=0. When i_start=1, latches mode, length, gap and budget, and moves to SEND. The head is valid on the cycle after i_start is sampled high (1-cycle latency). The first packet has no gap.
- SEND: o_valid=1. o_flit stays stable until i_ready=1 (no valid drop, no data change).
  - On each handshake, the flit index increments.
  - The tail (index = len-1) handshake increments o_pkt_count.
  - After the tail: if the budget is reached, go to DONE. Otherwise, if i_start=0, go to IDLE. Otherwise, if gap>0, go to GAP; if gap=0, send the next head on the following cycle (back-to-back).
- GAP: o_valid=0 for exactly gap cycles, then SEND.
- DONE: o_done=1, o_valid=0. Stays until i_start=0, then IDLE; counters hold their values.
- Length: i_pkt_len=0 is treated as 1; a single-flit packet uses type HEADTAIL. Values >MAX_PKT_LEN are clamped to MAX_PKT_LEN.
- Destination is computed when a head is generated:
  - mode 0: i_fixed_dest.
  - mode 1: lfsr[DEST_W-1:0]; if that equals SRC_ID, use +1 modulo NUM_NODES.
  - mode 2: ~SRC_ID truncated to DEST_W.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances only on a head handshake.
- i_start falling mid-packet: the current packet completes, then the FSM goes to IDLE. Packets are never truncated.
- Configuration inputs are sampled only at the IDLE→SEND transition; changes during a run are ignored.
- Budget counts completed packets. o_pkt_count and o_flit_count wrap modulo 2^CNT_W. In unlimited mode the FSM never enters DONE.
- Synchronous reset has priority in any state: o_valid drops the next edge, and a partial packet is abandoned.
- o_busy=1 from head generation through the tail handshake.

Decomposition:
- router_pkg additions:
  - flit_type_t enum (HEAD, BODY, TAIL, HEADTAIL).
  - tg_mode_t enum (TG_FIXED, TG_UNIFORM, TG_BITCOMP).
  - field-offset localparams for the head flit.
  - MAX_PKT_LEN default.
- Sub-module tg_lfsr16: parametrised seed; ports clk, reset, i_advance, o_value.

Test Plan:
- Mode 0, dest=5, len=3, gap=0, budget=2, ready=1 → six flits, types 10,00,01,10,00,01; head dest=5; o_pkt_count=2; o_done=1 the cycle after the last tail.
- Mode 2, SRC_ID=3, NUM_NODES=16, len=1 → every flit has type 11 and dest=12; gap=4 gives exactly 4 cycles with o_valid=0 between flits.
- Backpressure: i_ready low for 7 cycles mid-packet → o_valid stays 1, o_flit is unchanged, o_flit_count is frozen; transfer resumes at the same index.
- Mode 1, seed 16'hACE1, 32 packets → dests match the reference LFSR model; no dest equals SRC_ID.
- i_start dropped after the head of a len=4 packet → three more flits, then IDLE with o_valid=0; no new head is generated.
- Reset asserted mid-packet → the next cycle shows o_valid=0, counters=0; after restart the first head dest matches the seed-derived value.
- i_pkt_len=0 and i_pkt_len=15 with MAX_PKT_LEN=8 → packet lengths 1 and 8.
